// File: rtl/seq_pkg.sv
// Shared types for the serializer and the sequence detectors downstream.
// Holds the serializer state encoding and the legal WIDTH range.
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SHIFT  = 2'b01,
        PARITY = 2'b10
    } piso_state_t;

    localparam int PISO_WIDTH_MIN = 2;
    localparam int PISO_WIDTH_MAX = 32;

endpackage

// File: rtl/piso_shreg.sv
// Load/shift register plus bits-remaining down-counter for piso_serializer.
// Ports: clk, rst (sync, active-high), load_i, shift_i, din_i[WIDTH-1:0],
//        next_msb_o (bit that becomes MSB after a shift), last_bit_o (cnt==1).
module piso_shreg
    import seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic [WIDTH-1:0] din_i,
    output logic             next_msb_o,
    output logic             last_bit_o
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    always_comb begin
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        if (load_i) begin
            shreg_d = din_i;
            cnt_d   = CW'(WIDTH);
        end else if (shift_i) begin
            shreg_d = shreg_q << 1;
            cnt_d   = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

    // x is registered, so the bit emitted after a shift is the one
    // currently just below the MSB.
    assign next_msb_o = shreg_q[WIDTH-2];
    assign last_bit_o = (cnt_q == CW'(1));

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out stage: MSB-first, one bit per clock, no gap
// between back-to-back words. Ports: clk, rst (sync, active-high),
// din[WIDTH-1:0], din_valid, din_ready, x, x_valid, busy.
// Macro PISO_PARITY_EN appends one even-parity bit after each word.
module piso_serializer
    import seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             x,
    output logic             x_valid,
    output logic             busy
);

    piso_state_t state_q, state_d;
    logic        x_q, x_d;
    logic        xv_q, xv_d;
    logic        accept;
    logic        shift_en;
    logic        last_bit;
    logic        next_msb;

`ifdef PISO_PARITY_EN
    logic        par_q, par_d;
`endif

    piso_shreg #(
        .WIDTH(WIDTH)
    ) u_shreg (
        .clk       (clk),
        .rst       (rst),
        .load_i    (accept),
        .shift_i   (shift_en),
        .din_i     (din),
        .next_msb_o(next_msb),
        .last_bit_o(last_bit)
    );

    always_comb begin
        din_ready = 1'b0;
        if (!rst) begin
            unique case (state_q)
                IDLE:    din_ready = 1'b1;
`ifdef PISO_PARITY_EN
                SHIFT:   din_ready = 1'b0;
                PARITY:  din_ready = 1'b1;
`else
                SHIFT:   din_ready = last_bit;
`endif
                default: din_ready = 1'b0;
            endcase
        end
    end

    assign accept   = din_valid && din_ready;
    assign shift_en = (state_q == SHIFT) && !accept;

    always_comb begin
        state_d = state_q;
        x_d     = 1'b0;
        xv_d    = 1'b0;
`ifdef PISO_PARITY_EN
        par_d   = par_q;
`endif
        unique case (state_q)
            IDLE: state_d = IDLE;
            SHIFT: begin
                if (!last_bit) begin
                    x_d  = next_msb;
                    xv_d = 1'b1;
                end else begin
`ifdef PISO_PARITY_EN
                    state_d = PARITY;
                    x_d     = par_q;
                    xv_d    = 1'b1;
`else
                    state_d = IDLE;
`endif
                end
            end
`ifdef PISO_PARITY_EN
            PARITY: state_d = IDLE;
`endif
            default: state_d = IDLE;
        endcase
        // A reload overrides whatever the current state would do next.
        if (accept) begin
            state_d = SHIFT;
            x_d     = din[WIDTH-1];
            xv_d    = 1'b1;
`ifdef PISO_PARITY_EN
            par_d   = ^din;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            x_q     <= 1'b0;
            xv_q    <= 1'b0;
`ifdef PISO_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            xv_q    <= xv_d;
`ifdef PISO_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign x       = x_q;
    assign x_valid = xv_q;
    assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer (WIDTH=8), with or without
// PISO_PARITY_EN; includes a 1101 overlapping detector model on x.
module tb_piso_serializer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din;
    logic       din_valid;
    logic       din_ready;
    logic       x;
    logic       x_valid;
    logic       busy;

    int checks   = 0;
    int failures = 0;
    int det      = 0;
    logic [2:0] hist;

`ifdef PISO_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    always #5 clk = ~clk;

    piso_serializer #(
        .WIDTH(8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .din      (din),
        .din_valid(din_valid),
        .din_ready(din_ready),
        .x        (x),
        .x_valid  (x_valid),
        .busy     (busy)
    );

    always @(posedge clk) begin
        if (rst) begin
            hist <= 3'b000;
            det  <= 0;
        end else if (x_valid) begin
            hist <= {hist[1:0], x};
            if ({hist, x} == 4'b1101) det <= det + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_chk(input string tag);
        #1;
        chk({tag, "_xv"}, 32'(x_valid), 0);
        chk({tag, "_x"}, 32'(x), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
    endtask

    // Called right after the accept edge; din_valid already low.
    task automatic expect_word(input string tag, input logic [7:0] w);
        for (int k = 0; k < 8; k++) begin
            #1;
            chk({tag, "_bit"}, 32'(x), 32'(w[7-k]));
            chk({tag, "_xv"}, 32'(x_valid), 1);
            chk({tag, "_busy"}, 32'(busy), 1);
            chk({tag, "_rdy"}, 32'(din_ready), 32'(!PAR && k == 7));
            tick();
        end
        if (PAR) begin
            #1;
            chk({tag, "_par"}, 32'(x), 32'(^w));
            chk({tag, "_par_xv"}, 32'(x_valid), 1);
            chk({tag, "_par_rdy"}, 32'(din_ready), 1);
            tick();
        end
    endtask

    initial begin
        logic [15:0] w16;
        logic [17:0] w18;

        // Reset with valid held high
        rst       = 1'b1;
        din_valid = 1'b1;
        din       = 8'hAA;
        #1;
        chk("rst_rdy0", 32'(din_ready), 0);
        repeat (2) begin
            tick();
            #1;
            chk("rst_rdy", 32'(din_ready), 0);
            chk("rst_x", 32'(x), 0);
            chk("rst_xv", 32'(x_valid), 0);
            chk("rst_busy", 32'(busy), 0);
        end
        rst       = 1'b0;
        din_valid = 1'b0;
        #1;
        chk("rel_rdy", 32'(din_ready), 1);

        // Single word
        tick();
        din       = 8'hD0;
        din_valid = 1'b1;
        #1;
        chk("d0_rdy", 32'(din_ready), 1);
        tick();
        din_valid = 1'b0;
        expect_word("d0", 8'hD0);
        idle_chk("d0_idle");
        chk("d0_det", 32'(det), 1);

`ifndef PISO_PARITY_EN
        // Back-to-back A5, 3C
        din       = 8'hA5;
        din_valid = 1'b1;
        w16       = 16'hA53C;
        #1;
        chk("b2b_rdy0", 32'(din_ready), 1);
        tick();
        din = 8'h3C;
        for (int k = 0; k < 16; k++) begin
            if (k == 8) din_valid = 1'b0;
            #1;
            chk("b2b_bit", 32'(x), 32'(w16[15-k]));
            chk("b2b_xv", 32'(x_valid), 1);
            chk("b2b_busy", 32'(busy), 1);
            chk("b2b_rdy", 32'(din_ready), 32'(k == 7 || k == 15));
            tick();
        end
        idle_chk("b2b_idle");
`else
        // Parity words
        din       = 8'h07;
        din_valid = 1'b1;
        #1;
        tick();
        din_valid = 1'b0;
        expect_word("p07", 8'h07);
        idle_chk("p07_idle");
        din       = 8'h03;
        din_valid = 1'b1;
        #1;
        tick();
        din_valid = 1'b0;
        expect_word("p03", 8'h03);
        idle_chk("p03_idle");

        // Back-to-back with parity: 9-cycle period
        din       = 8'h07;
        din_valid = 1'b1;
        w18       = {8'h07, 1'b1, 8'h03, 1'b0};
        #1;
        tick();
        din = 8'h03;
        for (int k = 0; k < 18; k++) begin
            if (k == 9) din_valid = 1'b0;
            #1;
            chk("pb2b_bit", 32'(x), 32'(w18[17-k]));
            chk("pb2b_xv", 32'(x_valid), 1);
            chk("pb2b_busy", 32'(busy), 1);
            chk("pb2b_rdy", 32'(din_ready), 32'(k == 8 || k == 17));
            tick();
        end
        idle_chk("pb2b_idle");
`endif

        // Stall: valid drops, din changes, word still completes
        din       = 8'h5A;
        din_valid = 1'b1;
        #1;
        tick();
        din_valid = 1'b0;
        din       = 8'hFF;
        expect_word("stall", 8'h5A);
        repeat (3) begin
            idle_chk("stall_idle");
            chk("stall_rdy", 32'(din_ready), 1);
            tick();
        end

        // Reset during bit 4 of FF
        din       = 8'hFF;
        din_valid = 1'b1;
        #1;
        tick();
        din_valid = 1'b0;
        repeat (4) begin
            #1;
            chk("mid_bit", 32'(x), 1);
            tick();
        end
        rst = 1'b1;
        #1;
        chk("mid_bit4", 32'(x), 1);
        chk("mid_rdy", 32'(din_ready), 0);
        tick();
        idle_chk("mid_rst");
        rst = 1'b0;
        #1;
        chk("mid_rel_rdy", 32'(din_ready), 1);
        tick();
        idle_chk("mid_drop");
        din       = 8'h81;
        din_valid = 1'b1;
        #1;
        tick();
        din_valid = 1'b0;
        expect_word("w81", 8'h81);
        idle_chk("w81_idle");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in, serial-out stage directly upstream of the Moore sequence detectors.
- Accepts a WIDTH-bit word on a valid/ready handshake and emits it MSB first, one bit per clock, on a registered serial output.
- The serial output drives a detector's `x` input.
- Back-to-back words stream with no idle gap, so patterns that straddle word boundaries reach the detector intact.

## Interface
- `WIDTH`, default 8: data word width; legal range 2..32.
- `clk`  input  1  rising-edge clock; the only clock.
- `rst`  input  1  synchronous, active-high reset.
- `din`  input  WIDTH  parallel word; sampled only on an accept edge.
- `din_valid`  input  1  `din` holds a word to send.
- `din_ready`  output  1  block can accept a word this cycle.
- `x`  output  1  serial bit, registered; 0 whenever `x_valid`=0.
- `x_valid`  output  1  `x` carries a data (or parity) bit, registered.
- `busy`  output  1  a word is in flight (state ≠ IDLE), registered.

## Operation
- **States:** IDLE, SHIFT; PARITY exists only with the macro enabled.
- **Registers:**
  - `shreg`, WIDTH bits.
  - `cnt`, $clog2(WIDTH+1) bits, holding the bits remaining.
  - `par`, 1 bit.
- **Accept condition:** `din_valid && din_ready` at a rising edge.
- **`din_ready` (combinational):**
  - 0 while `rst`=1.
  - Otherwise 1 in IDLE.
  - 1 in SHIFT when `cnt`==1 and parity is disabled.
  - 1 in PARITY.
  - 0 in all other cases.
- **On accept:**
  - `shreg`←`din`, `cnt`←WIDTH, `par`←^`din`.
  - Next state is SHIFT.
  - `x`←`din[WIDTH-1]`, `x_valid`←1.
- **SHIFT, each edge:**
  - `shreg`←`shreg`<<1 and `cnt`←`cnt`-1.
  - `x`←new `shreg[WIDTH-1]`, `x_valid`←1.
- **SHIFT, last bit (`cnt`==1):**
  - Without parity: go to IDLE, or reload if an accept occurs on this edge.
  - With parity: go to PARITY, with `x`←`par`.
- **PARITY:** one cycle only, then go to IDLE, or reload on accept.
- **IDLE with no accept:** `x`←0, `x_valid`←0, `busy`←0.
- **Valid handling:** `din_valid` may drop at any time with no effect on the word in flight. `din` is ignored except on accept edges.
- **Reset:**
  - `rst`=1 at an edge forces IDLE, `x`=0, `x_valid`=0, `busy`=0, `cnt`=0, `shreg`=0.
  - Reset takes priority over an accept on the same edge.
  - A word in flight is dropped with no partial completion.

## Timing
- **Latency:** accept at edge N; data bit k (k=0 is the MSB) appears on `x` during cycle N+1+k.
- **Throughput:**
  - One word per WIDTH cycles without parity.
  - One word per WIDTH+1 cycles with parity.
  - `x_valid` stays continuously high under sustained `din_valid`.
- **`busy`:** rises with the first bit and falls the cycle after the last bit if no reload occurs.
- **Reset release:** after `rst` deasserts, `din_ready`=1 in the same cycle, and the first accept is possible on the next edge.

## Configuration
- **`PISO_PARITY_EN` defined:**
  - PARITY state is compiled in.
  - One even-parity bit (XOR of the word) follows each word, so the ones count of WIDTH+1 bits is even.
  - `x_valid`=1 during the parity bit.
- **Undefined:**
  - No PARITY state and no `par` register.
  - Words are strictly WIDTH bits with no gap.

## Structure
- **Shared package `seq_pkg`:**
  - State encoding typedef `piso_state_t`: IDLE=2'b00, SHIFT=2'b01, PARITY=2'b10.
  - `WIDTH` bounds.
- **Sub-module:** one natural sub-module, `piso_shreg`. It holds the load/shift register and the down-counter and exports `last_bit`. The FSM, handshake and parity logic stay in `piso_serializer`.

## Test plan
1. **Reset:** `rst`=1 for 2 cycles with `din_valid`=1 -> `din_ready`=0, `x`=0, `x_valid`=0, `busy`=0; `din_ready`=1 after release.
2. **Single word:** WIDTH=8, `din`=8'hD0 accepted at edge N -> `x`=1,1,0,1,0,0,0,0 on cycles N+1..N+8 with `x_valid`=1. Then `x_valid`=0 and `x`=0. A downstream 1101 detector fires once.
3. **Back-to-back:** 8'hA5 then 8'h3C with `din_valid` held high -> 16 contiguous valid bits 10100101 00111100. `din_ready` pulses on the first-accept edge and on the 8th-bit cycle, and `busy` never drops.
4. **Stall:** `din_valid` drops mid-word -> all 8 bits still complete. Then IDLE, and `din_ready` stays high until the next valid.
5. **Reset mid-word:** `rst`=1 during bit 4 of 8'hFF -> next cycle `x`=0 and `x_valid`=0. The remaining bits are never emitted, and a following 8'h81 serializes from the MSB correctly.
6. **Parity (macro on):**
   - 8'h07 -> 9 bits, 9th=1.
   - 8'h03 -> 9th=0.
   - `din_ready` is high during the parity cycle, and back-to-back gives a 9-cycle period.
